// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shift unit: operation codes and FSM states.
package shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate step by 1 or 2 bit positions.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e              op,
  input  logic             two,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] y2;

  always_comb begin
    y1 = a;
    y2 = a;
    case (op)
      OP_SLL: begin
        y1 = {a[WIDTH-2:0], 1'b0};
        y2 = {a[WIDTH-3:0], 2'b00};
      end
      OP_SRL: begin
        y1 = {1'b0, a[WIDTH-1:1]};
        y2 = {2'b00, a[WIDTH-1:2]};
      end
      OP_SRA: begin
        y1 = {a[WIDTH-1], a[WIDTH-1:1]};
        y2 = {{2{a[WIDTH-1]}}, a[WIDTH-1:2]};
      end
      OP_ROTR: begin
        y1 = {a[0], a[WIDTH-1:1]};
        y2 = {a[1:0], a[WIDTH-1:2]};
      end
      default: ;
    endcase
    y = two ? y2 : y1;
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROTR unit: 2-bit steps then at most one 1-bit step, one per clock.
// state   | meaning
// S_IDLE  | waiting for start
// S_SHIFT | stepping acc until rem reaches zero (busy)
// S_DONE  | one-cycle done pulse; start here launches the next op with no bubble
module iterative_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout,
  output logic               busy,
  output logic               done
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [SHAMT_W-1:0]   rem_q, rem_d;
  op_e                  op_q, op_d;
  logic [WIDTH-1:0]     dout_q, dout_d;

  logic                 two;
  logic [SHAMT_W-1:0]   rem_next;
  logic [WIDTH-1:0]     stepped;

  // Taking 2-bit steps while rem>=2 leaves any odd single step for last.
  assign two      = (rem_q >= SHAMT_W'(2));
  assign rem_next = rem_q - (two ? SHAMT_W'(2) : SHAMT_W'(1));

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op  (op_q),
    .two (two),
    .a   (acc_q),
    .y   (stepped)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    op_d    = op_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          acc_d = din;
          rem_d = shamt;
          op_d  = op_e'(op);
          if (shamt == '0) begin
            state_d = S_DONE;
            dout_d  = din;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        acc_d = stepped;
        rem_d = rem_next;
        if (rem_next == '0) begin
          dout_d  = stepped;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= OP_SLL;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;
  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);

endmodule
